// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the fifo stream reader slice.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 32;

    typedef logic [31:0] fifo_stat_t;

    // Bits needed to index 'value' entries; never returns less than 1.
    function automatic int clog2_safe(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_stream_buf.sv
// stream_buf: BUF_DEPTH-entry circular prefetch store with push, pop, head data and count.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int BUF_DEPTH  = 2,
    localparam int PW = clog2_safe(BUF_DEPTH),
    localparam int CW = clog2_safe(BUF_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [CW-1:0]         o_count
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push_s, do_pop_s;

    // Pops on an empty store and pushes into a full one are ignored.
    assign do_pop_s  = i_pop && (count_q != {CW{1'b0}});
    assign do_push_s = i_push && ((count_q != CW'(BUF_DEPTH)) || do_pop_s);

    // Next-state for storage, pointers and occupancy; clear wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clr) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is zeroed on reset so the head reads 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master turning a 1-cycle-latency fifo into a valid/ready stream.
// Optional transfer/stall counters are built when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output fifo_stat_t            o_xfer_count,
    output fifo_stat_t            o_stall_count
`endif
);

    localparam int CW = clog2_safe(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [CW-1:0] count_s;
    logic [OW-1:0] occupancy_s;
    logic          pop_s;
    logic          rd_en_s;
    logic          inflight_q, inflight_d;

    assign o_valid = (count_s != {CW{1'b0}});
    assign pop_s   = o_valid && i_ready;

    // Fetch only when the word already owed plus this one still fits after this cycle's pop.
    always_comb begin
        occupancy_s = {1'b0, count_s} + OW'(inflight_q) - OW'(pop_s);
        if (!i_rst && !i_flush && !i_fifo_empty && (occupancy_s < OW'(BUF_DEPTH))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        inflight_d = rd_en_s;
    end

    // In-flight flag: a word returns on the edge after each read enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign o_fifo_rd_en = rd_en_s;

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_flush),
        .i_push      (inflight_q),
        .i_push_data (i_fifo_data),
        .i_pop       (pop_s),
        .o_head      (o_data),
        .o_count     (count_s)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    fifo_stat_t xfer_q, xfer_d;
    fifo_stat_t stall_q, stall_d;

    // Counters wrap naturally; flush deliberately leaves them alone.
    always_comb begin
        xfer_d  = xfer_q;
        stall_d = stall_q;
        if (pop_s) begin
            xfer_d = xfer_q + 32'd1;
        end else begin
            xfer_d = xfer_q;
        end
        if (o_valid && !i_ready) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Statistics registers, cleared by reset only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xfer_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
        end
    end

    assign o_xfer_count  = xfer_q;
    assign o_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: randomized stimulus against an outstanding-word scoreboard.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int BD = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_fifo_empty = 1'b1;
    logic          o_fifo_rd_en;
    logic [DW-1:0] i_fifo_data = '0;
    logic          i_flush = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0]   o_xfer_count;
    logic [31:0]   o_stall_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_fifo_data  (i_fifo_data),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready)
`ifdef FIFO_STREAM_READER_STATS_EN
        ,
        .o_xfer_count (o_xfer_count),
        .o_stall_count(o_stall_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: source fifo contents, words fetched but not yet delivered, delivered words.
    logic [DW-1:0] src[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] got[$];
    bit            fetched_last = 1'b0;
    int            xfer_exp = 0;
    int            stall_exp = 0;
    logic          obs_rd, obs_valid, obs_acc;
    logic [DW-1:0] obs_data;

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model after the rising edge.
    task automatic cycle(input bit rdy, input bit fl, input bit force_empty);
        int            avail;
        bit            exp_valid, exp_pop, exp_rd;
        logic [DW-1:0] w;
        i_ready      = rdy;
        i_flush      = fl;
        i_fifo_empty = force_empty || (src.size() == 0);
        @(negedge i_clk);
        avail     = sb.size() - (fetched_last ? 1 : 0);
        exp_valid = (avail > 0);
        exp_pop   = exp_valid && rdy;
        exp_rd    = !fl && !i_fifo_empty && ((sb.size() - (exp_pop ? 1 : 0)) < BD);
        obs_rd    = o_fifo_rd_en;
        obs_valid = o_valid;
        obs_data  = o_data;
        obs_acc   = o_valid && rdy;
        n_checks++;
        if (o_fifo_rd_en !== exp_rd) $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, o_fifo_rd_en, exp_rd);
        else n_pass++;
        n_checks++;
        if (o_valid !== exp_valid) $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, o_valid, exp_valid);
        else n_pass++;
        if (exp_valid) begin
            n_checks++;
            if (o_data !== sb[0]) $display("FAIL data cyc=%0d got=%h exp=%h", cyc, o_data, sb[0]);
            else n_pass++;
        end
        n_checks++;
        if (dut.u_buf.o_count > BD) $display("FAIL count_bound cyc=%0d got=%0d max=%0d", cyc, dut.u_buf.o_count, BD);
        else n_pass++;
`ifdef FIFO_STREAM_READER_STATS_EN
        n_checks++;
        if (o_xfer_count !== xfer_exp) $display("FAIL xfer_count cyc=%0d got=%0d exp=%0d", cyc, o_xfer_count, xfer_exp);
        else n_pass++;
        n_checks++;
        if (o_stall_count !== stall_exp) $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc, o_stall_count, stall_exp);
        else n_pass++;
`endif
        if (exp_pop) begin
            got.push_back(o_data);
            xfer_exp++;
        end
        if (exp_valid && !rdy) stall_exp++;
        @(posedge i_clk);
        #1;
        if (exp_pop) void'(sb.pop_front());
        fetched_last = 1'b0;
        if (fl) begin
            sb.delete();
        end else if (exp_rd) begin
            w           = src.pop_front();
            i_fifo_data = w;
            sb.push_back(w);
            fetched_last = 1'b1;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (sb.size() != 0 || src.size() != 0); k++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        src.delete();
        for (int i = 0; i < 3; i++) src.push_back(32'h11 + i);
        i_fifo_empty = 1'b0;
        i_ready      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", o_fifo_rd_en);
            else n_pass++;
            n_checks++;
            if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid);
            else n_pass++;
            n_checks++;
            if (o_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", o_data);
            else n_pass++;
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        src.delete();
        sb.delete();
        fetched_last = 1'b0;
        xfer_exp     = 0;
        stall_exp    = 0;
    endtask

    task automatic test_streaming();
        int first_rd, first_valid, first_acc, last_acc;
        first_rd = -1; first_valid = -1; first_acc = -1; last_acc = -1;
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(32'h11 + i);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (obs_rd && first_rd < 0) first_rd = i;
            if (obs_valid && first_valid < 0) first_valid = i;
            if (obs_acc) begin
                if (first_acc < 0) first_acc = i;
                last_acc = i;
            end
        end
        n_checks++;
        if (first_valid - first_rd !== 2) $display("FAIL stream_latency got=%0d exp=2", first_valid - first_rd);
        else n_pass++;
        n_checks++;
        if (last_acc - first_acc !== 7) $display("FAIL stream_rate got=%0d exp=7", last_acc - first_acc);
        else n_pass++;
        n_checks++;
        if (got.size() !== 8) $display("FAIL stream_words got=%0d exp=8", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_checks++;
            if (got[i] !== 32'h11 + i) $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], 32'h11 + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        int            fetches;
        got.delete();
        fetches = 0;
        held    = '0;
        for (int i = 0; i < 8; i++) src.push_back(32'h21 + i);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (obs_rd) fetches++;
            if (i == 0) begin
                held = obs_data;
            end else begin
                n_checks++;
                if (obs_data !== held) $display("FAIL bp_stable i=%0d got=%h exp=%h", i, obs_data, held);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_rd !== 1'b0) $display("FAIL bp_rd_low got=%b exp=0", obs_rd);
        else n_pass++;
        n_checks++;
        if (fetches > BD) $display("FAIL bp_fetches got=%0d max=%0d", fetches, BD);
        else n_pass++;
        drain();
        n_checks++;
        if (got.size() !== 8) $display("FAIL bp_words got=%0d exp=8", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_checks++;
            if (got[i] !== 32'h21 + i) $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], 32'h21 + i);
            else n_pass++;
        end
    endtask

    task automatic test_flush_inflight();
        got.delete();
        for (int i = 0; i < 6; i++) src.push_back(32'h31 + i);
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_rd !== 1'b1) $display("FAIL flush_rd_n got=%b exp=1", obs_rd);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs_rd !== 1'b0) $display("FAIL flush_rd_suppressed got=%b exp=0", obs_rd);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", obs_valid);
        else n_pass++;
        drain();
        n_checks++;
        if (got.size() !== 5) $display("FAIL flush_words got=%0d exp=5", got.size());
        else n_pass++;
        if (got.size() > 0) begin
            n_checks++;
            if (got[0] !== 32'h32) $display("FAIL flush_next got=%h exp=32", got[0]);
            else n_pass++;
        end
    endtask

    task automatic test_empty_toggle();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            src.push_back(w);
            exp_q.push_back(w);
        end
        for (int k = 0; k < 60; k++) cycle(1'($urandom_range(0, 1)), 1'b0, (k % 2) == 0);
        drain();
        n_checks++;
        if (got.size() !== 20) $display("FAIL toggle_words got=%0d exp=20", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 20; i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) $display("FAIL toggle_order idx=%0d got=%h exp=%h", i, got[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if (src.size() < 4 && $urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 3; j++) src.push_back($urandom);
            end
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) src.push_back(32'h41 + i);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", o_valid);
        else n_pass++;
        n_checks++;
        if (o_fifo_rd_en !== 1'b0) $display("FAIL midrst_rd_en got=%b exp=0", o_fifo_rd_en);
        else n_pass++;
        n_checks++;
        if (o_data !== 32'h0) $display("FAIL midrst_data got=%h exp=0", o_data);
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        src.delete();
        sb.delete();
        fetched_last = 1'b0;
        xfer_exp     = 0;
        stall_exp    = 0;
    endtask

    task automatic test_stats();
        for (int i = 0; i < 10; i++) src.push_back($urandom);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        drain();
`ifdef FIFO_STREAM_READER_STATS_EN
        n_checks++;
        if (o_xfer_count !== 32'd10) $display("FAIL stats_xfer got=%0d exp=10", o_xfer_count);
        else n_pass++;
        n_checks++;
        if (o_stall_count !== 32'd3) $display("FAIL stats_stall got=%0d exp=3", o_stall_count);
        else n_pass++;
`endif
        cycle(1'b1, 1'b1, 1'b0);
`ifdef FIFO_STREAM_READER_STATS_EN
        n_checks++;
        if (o_xfer_count !== 32'd10) $display("FAIL stats_xfer_flush got=%0d exp=10", o_xfer_count);
        else n_pass++;
        n_checks++;
        if (o_stall_count !== 32'd3) $display("FAIL stats_stall_flush got=%0d exp=3", o_stall_count);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        drain();
        test_flush_inflight();
        test_empty_toggle();
        test_random();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
